tcam_array: RTL and testbench
=============================

Name: tcam_array

Overview:
- Synthesizable responder for the TCAM macro command interface: 16x8 ternary CAM with per-entry valid bits.
- Stands in place of the hard macro behind the TCAM controller, for simulation and FPGA builds.
- Accepts one command per clock (write, read, compare, flush).
- Returns registered read data, valid bit, hit flag and one-hot-per-entry hit vector.

Parameters:
- AddressSize, 4, address width
- Bits, 8, word width (data and care arrays)
- Words, 16, number of entries (≤ 2**AddressSize)
- BankSize, 1, width of bank-enable vector

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- CS  in  1  chip select; no command sampled when 0
- FLUSH  in  1  clear all valid bits
- VBE  in  1  valid-bit enable (write: update valid; read: report valid)
- DCS  in  1  array select: 1 = data array, 0 = care array
- WR  in  1  write command
- RD  in  1  read command
- CMP  in  1  compare command
- DI  in  Bits  write data / compare key
- MSKB  in  Bits  write: per-bit write enable; compare: per-bit key mask (1 = bit compared)
- VBI  in  1  valid value to write
- A  in  AddressSize  entry address for WR/RD
- CBE  in  BankSize  bank disable, active-high; any bit set blocks all commands
- DO  out  Bits  read data
- VBO  out  1  read valid bit
- HIT  out  1  OR of HITLINE
- HITLINE  out  Words  bit i = entry i matched
- CMD_ERR  out  1  one-cycle pulse on illegal command

Behaviour:
- All commands are sampled at the rising clk edge when CS=1 and CBE=0. Otherwise storage and all outputs hold, and CMD_ERR=0.
- Reset (async, rst_n=0):
  - every entry: data=0, care=0, valid=0
  - outputs: DO=0, VBO=0, HIT=0, HITLINE=0, CMD_ERR=0
  - A reset mid-operation discards the in-flight command.
- Command decode, priority FLUSH > others:
  - FLUSH=1: all valid bits cleared at that edge; WR/RD/CMP ignored; HIT/HITLINE cleared; DO/VBO hold.
  - Otherwise exactly one of WR/RD/CMP may be 1.
  - Two or more set: no storage update, outputs hold, CMD_ERR=1 for one cycle.
- WR:
  - Target is the data array (DCS=1) or care array (DCS=0) at entry A.
  - Bit i is written with DI[i] only where MSKB[i]=1.
  - If VBE=1, valid[A] <= VBI.
  - Visible to RD/CMP sampled at the next edge, never the same edge.
- RD (latency 1):
  - At the edge, DO <= selected array[A].
  - VBO <= VBE ? valid[A] : 0.
  - DO/VBO hold until the next RD.
- CMP (latency 1): entry i matches iff all of the following hold:
  - valid[i]=1
  - for every bit b with MSKB[b]=1 and care[i][b]=1, data[i][b]==DI[b]
  - Registered: HITLINE <= match vector; HIT <= |match.
  - Held until the next CMP or FLUSH.
  - An entry with care=0 and valid=1 matches any key.
- Address range: A ≥ Words on WR/RD means no update, DO=0, VBO=0, CMD_ERR=1.
- WR then CMP on consecutive cycles to the same entry: the compare sees the new contents.
- No other state; no back-pressure; one command per cycle sustained.

Decomposition:
- tcam_pkg holds:
  - default parameters
  - op enum: OP_NONE, OP_FLUSH, OP_WR, OP_RD, OP_CMP, OP_ERR
  - the decode function from {FLUSH, WR, RD, CMP}
- Sub-module tcam_entry: one word's data/care/valid registers, write/flush logic and a combinational match output. tcam_array instantiates Words copies and adds decode, read mux and output registers.

Test Plan:
- Reset, then RD A=5 DCS=1 VBE=1 -> DO=0x00, VBO=0; CMP DI=0x00 MSKB=0xFF -> HIT=0, HITLINE=0x0000.
- Write entry 3:
  - WR A=3 DCS=1 DI=0xA0 MSKB=0xFF VBE=1 VBI=1
  - then WR A=3 DCS=0 DI=0xF0 MSKB=0xFF VBE=0
  - then CMP DI=0xA5 MSKB=0xF0 -> HITLINE=0x0008, HIT=1
  - CMP DI=0xB0 -> HIT=0
- Partial write: with entry 3 data 0xA0, WR A=3 DCS=1 DI=0x0F MSKB=0x0F -> RD A=3 DCS=1 gives DO=0xAF.
- Multiple hits and flush:
  - entries 1 and 7 both valid, data 0x50, care 0xF0
  - CMP DI=0x5C MSKB=0xF0 -> HITLINE=0x0082
  - FLUSH -> HIT=0; next CMP -> HITLINE=0x0000
- Errors:
  - WR=1 with RD=1 -> CMD_ERR pulse, RD A=3 unchanged
  - CBE=1 with WR -> no write, CMD_ERR=0
- Reset mid-command: assert rst_n=0 asynchronously between edges during WR A=2 -> outputs 0 immediately, entry 2 valid=0 after release.

Source files
------------

// File: rtl/tcam_pkg.sv
// Shared defaults, command opcodes and command decode for the TCAM responder.
package tcam_pkg;

    localparam int unsigned DefAddressSize = 4;
    localparam int unsigned DefBits        = 8;
    localparam int unsigned DefWords       = 16;
    localparam int unsigned DefBankSize    = 1;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_FLUSH,
        OP_WR,
        OP_RD,
        OP_CMP,
        OP_ERR
    } op_e;

    // FLUSH wins outright; otherwise more than one of WR/RD/CMP is illegal.
    function automatic op_e decode_op(logic flush, logic wr, logic rd, logic cmp);
        logic [1:0] n;
        n = {1'b0, wr} + {1'b0, rd} + {1'b0, cmp};
        if (flush) begin
            return OP_FLUSH;
        end else if (n > 2'd1) begin
            return OP_ERR;
        end else if (wr) begin
            return OP_WR;
        end else if (rd) begin
            return OP_RD;
        end else if (cmp) begin
            return OP_CMP;
        end
        return OP_NONE;
    endfunction

endpackage

// File: rtl/tcam_entry.sv
// One TCAM word: data, care and valid registers with masked write, flush and
// a combinational ternary match against the compare key.
module tcam_entry import tcam_pkg::*; #(
    parameter int unsigned Bits = DefBits
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            wr_en,
    input  logic            wr_dcs,
    input  logic            wr_vbe,
    input  logic            wr_vbi,
    input  logic [Bits-1:0] wr_data,
    input  logic [Bits-1:0] wr_mask,
    input  logic [Bits-1:0] key,
    input  logic [Bits-1:0] key_mask,
    output logic [Bits-1:0] data,
    output logic [Bits-1:0] care,
    output logic            valid,
    output logic            match
);

    logic [Bits-1:0] data_q, care_q;
    logic            valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            care_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (wr_en) begin
            if (wr_dcs) begin
                data_q <= (data_q & ~wr_mask) | (wr_data & wr_mask);
            end else begin
                care_q <= (care_q & ~wr_mask) | (wr_data & wr_mask);
            end
            if (wr_vbe) begin
                valid_q <= wr_vbi;
            end
        end
    end

    // A bit disagrees only if both the key mask and the stored care select it.
    assign match = valid_q && (((data_q ^ key) & key_mask & care_q) == '0);
    assign data  = data_q;
    assign care  = care_q;
    assign valid = valid_q;

endmodule

// File: rtl/tcam_array.sv
// Synthesizable stand-in for the TCAM hard macro: command decode, entry array,
// read mux and registered read/compare/error outputs.
module tcam_array import tcam_pkg::*; #(
    parameter int unsigned AddressSize = DefAddressSize,
    parameter int unsigned Bits        = DefBits,
    parameter int unsigned Words       = DefWords,
    parameter int unsigned BankSize    = DefBankSize
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   CS,
    input  logic                   FLUSH,
    input  logic                   VBE,
    input  logic                   DCS,
    input  logic                   WR,
    input  logic                   RD,
    input  logic                   CMP,
    input  logic [Bits-1:0]        DI,
    input  logic [Bits-1:0]        MSKB,
    input  logic                   VBI,
    input  logic [AddressSize-1:0] A,
    input  logic [BankSize-1:0]    CBE,
    output logic [Bits-1:0]        DO,
    output logic                   VBO,
    output logic                   HIT,
    output logic [Words-1:0]       HITLINE,
    output logic                   CMD_ERR
);

    localparam logic [AddressSize:0] NumWords = (AddressSize + 1)'(Words);

    op_e              op;
    logic             cmd_en, addr_ok, flush_en, wr_en;
    logic [Bits-1:0]  data_arr [Words];
    logic [Bits-1:0]  care_arr [Words];
    logic [Words-1:0] valid_vec, match_vec;
    logic [Bits-1:0]  rd_data;
    logic             rd_valid;

    logic [Bits-1:0]  do_q;
    logic             vbo_q, hit_q, err_q;
    logic [Words-1:0] hitline_q;

    assign cmd_en   = CS && !(|CBE);
    assign op       = decode_op(FLUSH, WR, RD, CMP);
    assign addr_ok  = ({1'b0, A} < NumWords);
    assign flush_en = cmd_en && (op == OP_FLUSH);
    assign wr_en    = cmd_en && (op == OP_WR) && addr_ok;

    for (genvar i = 0; i < Words; i++) begin : g_entry
        tcam_entry #(
            .Bits(Bits)
        ) u_entry (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush_en),
            .wr_en   (wr_en && (A == AddressSize'(i))),
            .wr_dcs  (DCS),
            .wr_vbe  (VBE),
            .wr_vbi  (VBI),
            .wr_data (DI),
            .wr_mask (MSKB),
            .key     (DI),
            .key_mask(MSKB),
            .data    (data_arr[i]),
            .care    (care_arr[i]),
            .valid   (valid_vec[i]),
            .match   (match_vec[i])
        );
    end

    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        for (int i = 0; i < Words; i++) begin
            if (A == AddressSize'(i)) begin
                rd_data  = DCS ? data_arr[i] : care_arr[i];
                rd_valid = valid_vec[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            do_q      <= '0;
            vbo_q     <= 1'b0;
            hit_q     <= 1'b0;
            hitline_q <= '0;
            err_q     <= 1'b0;
        end else if (cmd_en) begin
            err_q <= 1'b0;
            case (op)
                OP_FLUSH: begin
                    hit_q     <= 1'b0;
                    hitline_q <= '0;
                end
                OP_WR: begin
                    if (!addr_ok) begin
                        do_q  <= '0;
                        vbo_q <= 1'b0;
                        err_q <= 1'b1;
                    end
                end
                OP_RD: begin
                    if (addr_ok) begin
                        do_q  <= rd_data;
                        vbo_q <= VBE && rd_valid;
                    end else begin
                        do_q  <= '0;
                        vbo_q <= 1'b0;
                        err_q <= 1'b1;
                    end
                end
                OP_CMP: begin
                    hitline_q <= match_vec;
                    hit_q     <= |match_vec;
                end
                OP_ERR:  err_q <= 1'b1;
                default: err_q <= 1'b0;
            endcase
        end else begin
            err_q <= 1'b0;
        end
    end

    assign DO      = do_q;
    assign VBO     = vbo_q;
    assign HIT     = hit_q;
    assign HITLINE = hitline_q;
    assign CMD_ERR = err_q;

endmodule

// File: tb/tb_tcam_array.sv
// Scoreboard bench for tcam_array: directed plan followed by randomized commands
// checked against a behavioural TCAM model.
module tb_tcam_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        CS, FLUSH, VBE, DCS, WR, RD, CMP, VBI;
    logic [7:0]  DI, MSKB;
    logic [3:0]  A;
    logic [0:0]  CBE;
    logic [7:0]  DO;
    logic        VBO, HIT, CMD_ERR;
    logic [15:0] HITLINE;

    tcam_array #(
        .AddressSize(4),
        .Bits       (8),
        .Words      (16),
        .BankSize   (1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .CS     (CS),
        .FLUSH  (FLUSH),
        .VBE    (VBE),
        .DCS    (DCS),
        .WR     (WR),
        .RD     (RD),
        .CMP    (CMP),
        .DI     (DI),
        .MSKB   (MSKB),
        .VBI    (VBI),
        .A      (A),
        .CBE    (CBE),
        .DO     (DO),
        .VBO    (VBO),
        .HIT    (HIT),
        .HITLINE(HITLINE),
        .CMD_ERR(CMD_ERR)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  dout;
        logic        vbo;
        logic        hit;
        logic [15:0] hl;
        logic        err;
    } exp_t;

    logic [7:0] m_data  [16];
    logic [7:0] m_care  [16];
    logic       m_valid [16];
    exp_t       m_out;
    exp_t       sb [$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_data[i]  = 8'h00;
            m_care[i]  = 8'h00;
            m_valid[i] = 1'b0;
        end
        m_out = '0;
    endtask

    // Applies the command currently on the pins to the model at the next edge.
    task automatic model_step();
        int n;
        logic miss;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_out.err = 1'b0;
        if (!CS || CBE != 1'b0) return;
        n = int'(WR) + int'(RD) + int'(CMP);
        if (FLUSH) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            m_out.hit = 1'b0;
            m_out.hl  = 16'h0000;
        end else if (n > 1) begin
            m_out.err = 1'b1;
        end else if (WR) begin
            for (int b = 0; b < 8; b++) begin
                if (MSKB[b]) begin
                    if (DCS) m_data[A][b] = DI[b];
                    else     m_care[A][b] = DI[b];
                end
            end
            if (VBE) m_valid[A] = VBI;
        end else if (RD) begin
            m_out.dout = DCS ? m_data[A] : m_care[A];
            m_out.vbo  = VBE ? m_valid[A] : 1'b0;
        end else if (CMP) begin
            for (int i = 0; i < 16; i++) begin
                miss = 1'b0;
                for (int b = 0; b < 8; b++) begin
                    if (MSKB[b] && m_care[i][b] && (m_data[i][b] != DI[b])) miss = 1'b1;
                end
                m_out.hl[i] = m_valid[i] && !miss;
            end
            m_out.hit = (m_out.hl != 16'h0000);
        end
    endtask

    task automatic drive(input logic cs, input logic cbe, input logic flush, input logic wr,
                         input logic rd, input logic cmp, input logic dcs, input logic vbe,
                         input logic vbi, input logic [7:0] di, input logic [7:0] mskb,
                         input logic [3:0] a);
        @(negedge clk);
        CS = cs; CBE = cbe; FLUSH = flush; WR = wr; RD = rd; CMP = cmp;
        DCS = dcs; VBE = vbe; VBI = vbi; DI = di; MSKB = mskb; A = a;
        model_step();
        sb.push_back(m_out);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0);
    endtask

    task automatic do_wr(input logic [3:0] a, input logic dcs, input logic [7:0] di,
                         input logic [7:0] mskb, input logic vbe, input logic vbi);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, dcs, vbe, vbi, di, mskb, a);
    endtask

    task automatic do_rd(input logic [3:0] a, input logic dcs, input logic vbe);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, dcs, vbe, 1'b0, 8'h00, 8'h00, a);
    endtask

    task automatic do_cmp(input logic [7:0] di, input logic [7:0] mskb);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, di, mskb, 4'h0);
    endtask

    task automatic do_flush();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0);
    endtask

    task automatic wait_out();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one scoreboard entry per clock edge the driver issued a command for.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_DO",      32'(DO),      32'(e.dout));
                check("sb_VBO",     32'(VBO),     32'(e.vbo));
                check("sb_HIT",     32'(HIT),     32'(e.hit));
                check("sb_HITLINE", 32'(HITLINE), 32'(e.hl));
                check("sb_CMD_ERR", 32'(CMD_ERR), 32'(e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic        r_cs, r_cbe, r_fl, r_wr, r_rd, r_cmp, r_dcs, r_vbe, r_vbi;
        logic [7:0]  r_di, r_mk;
        logic [3:0]  r_a;
        int          k;

        rst_n = 1'b0;
        CS = 0; CBE = 0; FLUSH = 0; WR = 0; RD = 0; CMP = 0;
        DCS = 0; VBE = 0; VBI = 0; DI = 0; MSKB = 0; A = 0;
        model_reset();
        #1;
        check("rst_DO",      32'(DO),      32'h0);
        check("rst_VBO",     32'(VBO),     32'h0);
        check("rst_HIT",     32'(HIT),     32'h0);
        check("rst_HITLINE", 32'(HITLINE), 32'h0);
        check("rst_CMD_ERR", 32'(CMD_ERR), 32'h0);
        idle();
        idle();
        @(negedge clk) rst_n = 1'b1;

        do_rd(4'd5, 1'b1, 1'b1);
        wait_out();
        check("rd5_DO",  32'(DO),  32'h00);
        check("rd5_VBO", 32'(VBO), 32'h0);
        do_cmp(8'h00, 8'hFF);
        wait_out();
        check("cmp0_HIT",     32'(HIT),     32'h0);
        check("cmp0_HITLINE", 32'(HITLINE), 32'h0000);

        do_wr(4'd3, 1'b1, 8'hA0, 8'hFF, 1'b1, 1'b1);
        do_wr(4'd3, 1'b0, 8'hF0, 8'hFF, 1'b0, 1'b0);
        do_cmp(8'hA5, 8'hF0);
        wait_out();
        check("e3_HITLINE", 32'(HITLINE), 32'h0008);
        check("e3_HIT",     32'(HIT),     32'h1);
        do_cmp(8'hB0, 8'hF0);
        wait_out();
        check("e3_miss_HIT", 32'(HIT), 32'h0);

        do_wr(4'd3, 1'b1, 8'h0F, 8'h0F, 1'b0, 1'b0);
        do_rd(4'd3, 1'b1, 1'b0);
        wait_out();
        check("partial_DO", 32'(DO), 32'hAF);

        do_wr(4'd1, 1'b1, 8'h50, 8'hFF, 1'b1, 1'b1);
        do_wr(4'd1, 1'b0, 8'hF0, 8'hFF, 1'b0, 1'b0);
        do_wr(4'd7, 1'b1, 8'h50, 8'hFF, 1'b1, 1'b1);
        do_wr(4'd7, 1'b0, 8'hF0, 8'hFF, 1'b0, 1'b0);
        do_cmp(8'h5C, 8'hF0);
        wait_out();
        check("multi_HITLINE", 32'(HITLINE), 32'h0082);
        do_flush();
        wait_out();
        check("flush_HIT",     32'(HIT),     32'h0);
        check("flush_HITLINE", 32'(HITLINE), 32'h0000);
        check("flush_DO_hold", 32'(DO),      32'hAF);
        do_cmp(8'h5C, 8'hF0);
        wait_out();
        check("post_flush_HITLINE", 32'(HITLINE), 32'h0000);

        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 4'd3);
        wait_out();
        check("multi_cmd_ERR", 32'(CMD_ERR), 32'h1);
        do_rd(4'd3, 1'b1, 1'b1);
        wait_out();
        check("err_rd3_DO",  32'(DO),      32'hAF);
        check("err_rd3_ERR", 32'(CMD_ERR), 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 4'd3);
        wait_out();
        check("cbe_ERR", 32'(CMD_ERR), 32'h0);
        do_rd(4'd3, 1'b1, 1'b0);
        wait_out();
        check("cbe_rd3_DO", 32'(DO), 32'hAF);

        // Reset asserted between edges while a write is on the pins.
        @(negedge clk);
        CS = 1; CBE = 0; FLUSH = 0; WR = 1; RD = 0; CMP = 0;
        DCS = 1; VBE = 1; VBI = 1; DI = 8'h11; MSKB = 8'hFF; A = 4'd2;
        #2 rst_n = 1'b0;
        model_reset();
        sb.push_back(m_out);
        #1;
        check("midrst_DO",  32'(DO),  32'h00);
        check("midrst_VBO", 32'(VBO), 32'h0);
        idle();
        @(negedge clk) rst_n = 1'b1;
        do_cmp(8'h00, 8'h00);
        wait_out();
        check("midrst_HITLINE", 32'(HITLINE), 32'h0000);
        do_rd(4'd2, 1'b1, 1'b1);
        wait_out();
        check("midrst_VBO2", 32'(VBO), 32'h0);

        for (int c = 0; c < 600; c++) begin
            r_cs  = ($urandom_range(0, 99) < 92);
            r_cbe = ($urandom_range(0, 19) == 0);
            r_fl  = ($urandom_range(0, 39) == 0);
            r_wr = 0; r_rd = 0; r_cmp = 0;
            k = int'($urandom_range(0, 9));
            if (k < 4)      r_wr = 1;
            else if (k < 6) r_rd = 1;
            else if (k < 9) r_cmp = 1;
            else begin
                r_wr  = 1;
                r_rd  = 1'($urandom_range(0, 1));
                r_cmp = !r_rd || 1'($urandom_range(0, 1));
            end
            r_dcs = 1'($urandom_range(0, 1));
            r_vbe = 1'($urandom_range(0, 1));
            r_vbi = ($urandom_range(0, 3) != 0);
            r_a   = 4'($urandom_range(0, 15));
            r_mk  = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(0, 255));
            if (r_cmp) begin
                r_di = m_data[4'($urandom_range(0, 15))];
                if ($urandom_range(0, 1) == 1) r_di = r_di ^ (8'h01 << $urandom_range(0, 7));
            end else begin
                r_di = 8'($urandom_range(0, 255));
            end
            drive(r_cs, r_cbe, r_fl, r_wr, r_rd, r_cmp, r_dcs, r_vbe, r_vbi, r_di, r_mk, r_a);
        end

        idle();
        idle();
        wait_out();
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
